// File: rtl/plic.sv
// plic: platform-level interrupt controller, claim/complete over a 2-cycle D-bus slave port.
// Define PLIC_EDGE_EN for rising-edge gateways; default is level-triggered.
module plic #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ss,
  input  logic              i_bstart,
  input  logic [31:0]       i_addr,
  input  logic              i_ttype,
  input  logic [1:0]        i_tsize,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_bdone,
  input  logic [NSRC-1:0]   i_src,
  output logic              o_irq_ext
);
  localparam logic       WRITE = 1'b1;
  localparam logic [1:0] WORD  = 2'd2;
  typedef enum logic {IDLE, RESP} state_t;
  state_t            r_state;
  logic [PRIO_W-1:0] r_prio [1:NSRC];
  logic [NSRC:1]     r_en, r_pend, r_infl;
  logic [PRIO_W-1:0] r_thr;
  logic              r_irq, r_bdone;
  logic [31:0]       r_rdata;
  logic [9:0]        w_off;
  logic [4:0]        w_pidx, w_id;
  logic              w_acc, w_wr, w_rd, w_is_prio, w_clm, w_cmp;
  logic [NSRC:1]     w_elig, w_claim, w_cpl, w_set;
  logic [PRIO_W-1:0] w_best;
  logic [31:0]       w_rmux;
  logic              w_unused;
  assign w_unused  = ^{i_addr[31:10], i_addr[1:0]};
  assign w_off     = i_addr[9:0];
  assign w_pidx    = w_off[6:2];
  assign w_acc     = r_state == IDLE && i_ss && i_bstart;
  assign w_wr      = w_acc && i_ttype == WRITE && i_tsize == WORD;
  assign w_rd      = w_acc && i_ttype != WRITE;
  assign w_is_prio = w_off[9:7] == 3'd0 && w_pidx != 5'd0 && w_pidx <= 5'(NSRC);
  assign w_clm     = w_rd && w_off == 10'h204;
  assign w_cmp     = w_wr && w_off == 10'h204;
  // Strict '>' keeps the lowest ID on priority ties; inflight sources wait for complete.
  always_comb begin
    w_elig  = '0;
    w_claim = '0;
    w_cpl   = '0;
    w_id    = '0;
    w_best  = '0;
    for (int k = 1; k <= NSRC; k++) begin
      w_elig[k] = r_pend[k] & ~r_infl[k] & r_en[k] & (r_prio[k] > r_thr);
      if (w_elig[k] && r_prio[k] > w_best) begin
        w_id   = 5'(k);
        w_best = r_prio[k];
      end
    end
    for (int k = 1; k <= NSRC; k++) begin
      w_claim[k] = w_clm && w_id == 5'(k);
      w_cpl[k]   = w_cmp && i_wdata == 32'(k);
    end
  end
  always_comb
    w_rmux = w_is_prio            ? 32'(r_prio[w_pidx]) :
             w_off == 10'h080     ? 32'({r_pend, 1'b0}) :
             w_off == 10'h100     ? 32'({r_en, 1'b0})   :
             w_off == 10'h200     ? 32'(r_thr)          :
             w_off == 10'h204     ? 32'(w_id)           : '0;
`ifdef PLIC_EDGE_EN
  logic [NSRC-1:0] r_s1, r_s2;
  always_ff @(posedge clk)
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_src;
      r_s2 <= r_s1;
    end
  assign w_set = r_s1 & ~r_s2;
`else
  // Claim wins over a same-cycle level set for the claimed ID.
  assign w_set = i_src & ~r_infl & ~w_claim;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_bdone <= 1'b0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
      r_en    <= '0;
      r_pend  <= '0;
      r_infl  <= '0;
      r_thr   <= '0;
      for (int k = 1; k <= NSRC; k++) r_prio[k] <= '0;
    end else begin
      r_state <= w_acc ? RESP : IDLE;
      r_bdone <= w_acc;
      if (w_acc) r_rdata <= w_rd ? w_rmux : '0;
      r_irq   <= |w_elig;
      if (w_wr && w_is_prio) r_prio[w_pidx] <= i_wdata[PRIO_W-1:0];
      if (w_wr && w_off == 10'h100) r_en <= i_wdata[NSRC:1];
      if (w_wr && w_off == 10'h200) r_thr <= i_wdata[PRIO_W-1:0];
      r_pend  <= w_set | (r_pend & ~w_claim);
      r_infl  <= w_claim | (r_infl & ~w_cpl);
    end
  // Reset landing on the response cycle suppresses bdone so the master restarts.
  assign o_bdone   = r_bdone & ~rst;
  assign o_rdata   = r_rdata;
  assign o_irq_ext = r_irq;
endmodule

// File: tb/tb_plic.sv
// tb_plic: directed scoreboard bench for plic (level mode, or edge mode with PLIC_EDGE_EN).
module tb_plic;
  localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;
  logic        clk = 0, rst = 1, ss = 0, bstart = 0, ttype = 0, bdone, irq;
  logic [1:0]  tsize = WORD;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [7:0]  src = 0;
  int          total = 0, bad = 0;
  logic [31:0] q[$];

  plic #(.NSRC(8), .PRIO_W(3)) dut (
    .clk(clk), .rst(rst), .i_ss(ss), .i_bstart(bstart), .i_addr(addr),
    .i_ttype(ttype), .i_tsize(tsize), .i_wdata(wdata), .o_rdata(rdata),
    .o_bdone(bdone), .i_src(src), .o_irq_ext(irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] e;
    @(negedge clk);
    ss = 1; bstart = 1; ttype = wr; tsize = sz; addr = a; wdata = d;
    chk("bdone_before", 32'(bdone), 0);
    @(posedge clk); #1;
    bstart = 0;
    chk("bdone_latency", 32'(bdone), 1);
    if (!wr) begin
      if (q.size() == 0) chk("scoreboard_empty", 1, 0);
      else begin
        e = q.pop_front();
        chk($sformatf("rd_0x%0h", a), rdata, e);
      end
    end
    @(posedge clk); #1;
    ss = 0;
    chk("bdone_one_cycle", 32'(bdone), 0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    q.push_back(e);
    xfer(0, WORD, a, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(1, WORD, a, d);
  endtask

  initial begin
    cyc(3);
    chk("rst_bdone", 32'(bdone), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 0;
    rd(32'h080, 0); rd(32'h100, 0); rd(32'h200, 0); rd(32'h204, 0);
    chk("irq_idle", 32'(irq), 0);
    xfer(1, BYTE, 32'h100, 32'hFF);
    rd(32'h100, 0);
    wr(32'h018, 6); rd(32'h018, 6);
    xfer(1, HALF, 32'h018, 1);
    rd(32'h018, 6);
    wr(32'h000, 7); rd(32'h000, 0);
    wr(32'h300, 32'hFFFF_FFFF); rd(32'h300, 0);
    wr(32'h024, 7); rd(32'h024, 0);
`ifdef PLIC_EDGE_EN
    wr(32'h004, 3); wr(32'h100, 32'h02);
    @(negedge clk); src = 8'h01;
    @(negedge clk); src = 8'h00;
    cyc(1); chk("edge_irq_n1", 32'(irq), 0);
    cyc(1); chk("edge_irq_n2", 32'(irq), 1);
    rd(32'h204, 1);
    wr(32'h204, 1); cyc(2);
    chk("edge_irq_done", 32'(irq), 0);
    rd(32'h204, 0);
    @(negedge clk); src = 8'h01;
    cyc(3);
    rd(32'h204, 1);
    wr(32'h204, 1); cyc(3);
    rd(32'h204, 0);
    chk("edge_held_irq", 32'(irq), 0);
`else
    wr(32'h00C, 5); wr(32'h100, 32'h08); wr(32'h200, 2);
    @(negedge clk); src = 8'h04;
    cyc(1); chk("lvl_irq_n", 32'(irq), 0);
    cyc(1); chk("lvl_irq_n1", 32'(irq), 1);
    rd(32'h204, 3);
    chk("claim_drops_irq", 32'(irq), 0);
    wr(32'h204, 3);
    chk("cpl_irq_n1", 32'(irq), 0);
    cyc(1); chk("repend_irq", 32'(irq), 1);
    wr(32'h008, 4); wr(32'h014, 4); wr(32'h018, 6); wr(32'h100, 32'h64);
    src = 8'hFF;
    cyc(2);
    rd(32'h204, 6); rd(32'h204, 2); rd(32'h204, 5); rd(32'h204, 0);
    rd(32'h080, 32'h19A);
    chk("irq_all_claimed", 32'(irq), 0);
    wr(32'h204, 6);
    wr(32'h200, 6);
    chk("thr6_irq", 32'(irq), 0);
    rd(32'h204, 0);
    wr(32'h200, 5);
    chk("thr5_irq", 32'(irq), 1);
    rd(32'h200, 5);
    xfer(1, BYTE, 32'h100, 32'hFF);
    rd(32'h100, 32'h64);
    rd(32'h080, 32'h1DA);
    wr(32'h204, 9);
    rd(32'h080, 32'h1DA);
    wr(32'h204, 2);
    rd(32'h080, 32'h1DE);
`endif
    src = 0;
    cyc(2);
    @(negedge clk);
    ss = 1; bstart = 1; ttype = 0; tsize = WORD; addr = 32'h204;
    @(posedge clk); #1;
    bstart = 0; rst = 1; #1;
    chk("rst_mid_bdone", 32'(bdone), 0);
    @(posedge clk); #1;
    rst = 0; ss = 0;
    chk("rst_mid_bdone2", 32'(bdone), 0);
    chk("rst_mid_irq", 32'(irq), 0);
    rd(32'h018, 0); rd(32'h100, 0); rd(32'h200, 0); rd(32'h080, 0); rd(32'h204, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/plic.md
# plic

Platform-level interrupt controller that responds to D-bus transfers through a `slave_bus_if` slave port, behind the D-bus interconnect next to `clint`. It gathers `NSRC` external interrupt sources and holds per-source pending, priority and enable state. It arbitrates them against a threshold and drives a single external interrupt line to core-0. Software services an interrupt through the standard claim/complete register.

## Interface
- `NSRC`, 8: number of interrupt sources, IDs 1..NSRC (ID 0 = "no interrupt"), 1..31.
- `PRIO_W`, 3: priority/threshold field width in bits.
- `clk` in, 1: single clock; all state updates on posedge.
- `rst` in, 1: reset, synchronous, active-high.
- `bus` slave_bus_if, -: D-bus slave port. Signals used: `ss`, `bstart`, `addr`, `ttype` (READ/WRITE), `tsize` (BYTE/HALFWORD/WORD), `wdata`[31:0], `rdata`[31:0], `bdone`.
- `src` in, NSRC: interrupt sources; bit k is source ID k+1; synchronous to `clk`.
- `irq_ext` out, 1: external interrupt request to core-0 (`irq_ext` input of `rv_core`).

## Operation
- Register map (offset = `addr[9:0]`, word aligned):
  - 0x000+4·i: priority[i], i=1..NSRC, RW, `PRIO_W` bits; offset 0x000 reads 0, writes ignored.
  - 0x080: pending bitmap, RO, bit i = source i.
  - 0x100: enable bitmap, RW, bit 0 hard-wired 0.
  - 0x200: threshold, RW.
  - 0x204: claim (read) / complete (write).
  - Unmapped offsets read 0; writes to them are ignored.
- Access size: writes take effect only with `tsize`==WORD; BYTE/HALFWORD writes complete normally but change nothing. Reads always return the full word.
- Bus FSM: IDLE, RESP.
  - IDLE -> RESP on `ss && bstart`; the register access executes in that cycle.
  - RESP: `bdone`=1 for exactly one cycle, with `rdata` valid; then -> IDLE.
  - The master holds `addr`/`ttype`/`tsize`/`wdata` stable until `bdone`.
  - `bstart` while in RESP is ignored; `ss` low means no response.
- Gateway, per source (level mode):
  - `pending[i]` sets when `src[i]`=1 and `inflight[i]`=0.
  - Claim clears `pending[i]` and sets `inflight[i]`.
  - A complete with ID i clears `inflight[i]`. Complete with ID 0, ID >NSRC, or a non-inflight ID is ignored.
  - A level still asserted after complete re-pends on the next cycle.
- Eligible source = pending & enabled & priority > threshold. Priority 0 never interrupts.
- Claim read returns the eligible ID with the highest priority; ties go to the lowest ID. Returns 0 if nothing is eligible, with no state change.
- `irq_ext` = registered OR of eligible.

## Timing
- Reset values: `bdone`=0, `rdata`=0, `irq_ext`=0, FSM=IDLE; all priority, enable, threshold, pending and inflight bits = 0.
- Bus latency: `bdone` asserts on the cycle after `bstart`, and every transfer takes exactly 2 cycles. Max throughput is one transfer per 2 cycles.
- `src[i]` rising at edge N -> `pending[i]`=1 after edge N -> `irq_ext`=1 after edge N+1.
- A claim or register write at edge N updates `irq_ext` after edge N+1.
- Simultaneous events:
  - A source that becomes pending in the same cycle as a claim read is not considered by that claim.
  - Claim has priority over the gateway set for the claimed ID, so no double pend.
- `rst` mid-transfer: `bdone` does not assert, the FSM returns to IDLE, all state is cleared, and the master must restart the transfer.

## Configuration
- `PLIC_EDGE_EN` defined: each source is registered and rising-edge detected.
  - `pending[i]` sets on `src[i]` 0->1, even while inflight; the edge is latched and presented after complete.
  - Held levels do not re-pend.
  - Adds one cycle: edge at N -> `irq_ext` after N+2.
- `PLIC_EDGE_EN` undefined: level-triggered gateway as described in Operation.

## Test plan
- Reset, then read 0x080, 0x100, 0x200, 0x204 -> all 0x0; `irq_ext`=0; each `bdone` arrives exactly 1 cycle after `bstart`.
- priority[3]=5, enable=0x08, threshold=2, assert `src[2]` -> `irq_ext`=1 two cycles later. Claim read returns 3 and `irq_ext` drops. Write 3 to 0x204 with `src[2]` still high -> re-pends and `irq_ext` returns.
- priority[2]=4, priority[5]=4, priority[6]=6, all enabled, all sources high -> claims return 6, 2, 5, then 0.
- threshold=6 with priority[6]=6 pending and enabled -> `irq_ext`=0 and claim returns 0. Threshold=5 -> `irq_ext`=1.
- BYTE write 0xFF to 0x100 -> enable stays 0x0. Complete write of 9 with NSRC=8 -> no state change.
- Assert `rst` in the RESP cycle of a claim -> no `bdone`, all registers 0. With `PLIC_EDGE_EN`: a 1-cycle `src[0]` pulse pends ID 1, but a held level yields one claim only.
